// File: rtl/hazard_stall_unit.sv
// Load-use / branch / memory-wait hazard controller beside the ID/EX boundary.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1ID,
    input  logic [4:0]       rs2ID,
    input  logic             usesRs1ID,
    input  logic             usesRs2ID,
    input  logic [4:0]       rdEX,
    input  logic             lwEX,
    input  logic             EscRegEX,
    input  logic             branchTakenEX,
    input  logic             memReqMEM,
    input  logic             memReadyMEM,
    output logic             stallPC,
    output logic             stallIFID,
    output logic             flushIFID,
    output logic             flushIDEX,
    output logic             freezeAll,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic [CNT_W-1:0] freezeCount
);

    localparam logic [0:0]  ST_RUN       = 1'b0;
    localparam logic [0:0]  ST_MEMWAIT   = 1'b1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [15:0] WAIT_MAX     = 16'hFFFF;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_next;
    logic        r_mem_timeout;
    logic        w_load_use;
    logic        w_mem_wait;
    logic        w_freeze;
    logic        w_flush_br;
    logic        w_stall_lu;

    // Hazard detection and priority resolution; every control is gated off during reset.
    always_comb begin
        w_load_use = lwEX & ~EscRegEX & (rdEX != 5'd0) &
                     ((usesRs1ID & (rs1ID == rdEX)) | (usesRs2ID & (rs2ID == rdEX)));
        w_mem_wait = memReqMEM & ~memReadyMEM;
        w_freeze   = rst_n & w_mem_wait;
        w_flush_br = rst_n & ~w_mem_wait & branchTakenEX;
        w_stall_lu = rst_n & ~w_mem_wait & ~branchTakenEX & w_load_use;
    end

    // Zero-latency pipeline control outputs.
    always_comb begin
        stallPC   = w_freeze | w_stall_lu;
        stallIFID = w_freeze | w_stall_lu;
        flushIFID = w_flush_br;
        flushIDEX = w_flush_br | w_stall_lu;
        freezeAll = w_freeze;
    end

    // Next-state logic for the RUN / MEMWAIT controller.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_state_next = ST_MEMWAIT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (memReadyMEM || !memReqMEM) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_MEMWAIT;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // waitCnt holds the number of waiting cycles already completed, so it is 0 on the first one.
    always_comb begin
        w_wait_cnt_next = 16'd0;
        if (w_mem_wait) begin
            if (r_wait_cnt != WAIT_MAX) begin
                w_wait_cnt_next = r_wait_cnt + 16'd1;
            end else begin
                w_wait_cnt_next = r_wait_cnt;
            end
        end else begin
            w_wait_cnt_next = 16'd0;
        end
    end

    // State, watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_mem_wait && (r_wait_cnt == TIMEOUT_LAST)) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
        end
    end

    assign memTimeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? (v + {{(CNT_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt  <= {CNT_W{1'b0}};
            r_flush_cnt  <= {CNT_W{1'b0}};
            r_freeze_cnt <= {CNT_W{1'b0}};
        end else begin
            r_stall_cnt  <= sat_inc(r_stall_cnt, w_stall_lu);
            r_flush_cnt  <= sat_inc(r_flush_cnt, w_flush_br);
            r_freeze_cnt <= sat_inc(r_freeze_cnt, w_freeze);
        end
    end

    assign stallCount  = r_stall_cnt;
    assign flushCount  = r_flush_cnt;
    assign freezeCount = r_freeze_cnt;
`else
    assign stallCount  = {CNT_W{1'b0}};
    assign flushCount  = {CNT_W{1'b0}};
    assign freezeCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit (MEM_TIMEOUT = 8).
module tb_hazard_stall_unit;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [4:0]       rs1ID, rs2ID, rdEX;
    logic             usesRs1ID, usesRs2ID, lwEX, EscRegEX;
    logic             branchTakenEX, memReqMEM, memReadyMEM;
    logic             stallPC, stallIFID, flushIFID, flushIDEX, freezeAll, memTimeout;
    logic [CNT_W-1:0] stallCount, flushCount, freezeCount;
    logic [4:0]       ctl;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_unit #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1ID(rs1ID), .rs2ID(rs2ID), .usesRs1ID(usesRs1ID), .usesRs2ID(usesRs2ID),
        .rdEX(rdEX), .lwEX(lwEX), .EscRegEX(EscRegEX), .branchTakenEX(branchTakenEX),
        .memReqMEM(memReqMEM), .memReadyMEM(memReadyMEM),
        .stallPC(stallPC), .stallIFID(stallIFID), .flushIFID(flushIFID),
        .flushIDEX(flushIDEX), .freezeAll(freezeAll), .memTimeout(memTimeout),
        .stallCount(stallCount), .flushCount(flushCount), .freezeCount(freezeCount)
    );

    // {stallPC, stallIFID, flushIFID, flushIDEX, freezeAll}
    assign ctl = {stallPC, stallIFID, flushIFID, flushIDEX, freezeAll};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rs1ID = 5'd0; rs2ID = 5'd0; rdEX = 5'd0;
        usesRs1ID = 1'b0; usesRs2ID = 1'b0; lwEX = 1'b0; EscRegEX = 1'b1;
        branchTakenEX = 1'b0; memReqMEM = 1'b0; memReadyMEM = 1'b0;
    endtask

    task automatic load_use_rs1();
        lwEX = 1'b1; EscRegEX = 1'b0; rdEX = 5'd5; rs1ID = 5'd5; usesRs1ID = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        load_use_rs1();
        branchTakenEX = 1'b1; memReqMEM = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== 5'b00000) begin n_err++; $display("FAIL reset_ctl: ctl=%b expected %b", ctl, 5'b00000); end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (memTimeout !== 1'b0 || dut.r_state !== 1'b0 || dut.r_wait_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_regs: timeout=%b state=%b waitCnt=%0d expected 0 0 0", memTimeout, dut.r_state, dut.r_wait_cnt);
        end
        n_vec++;
        if (stallCount !== 32'd0 || flushCount !== 32'd0 || freezeCount !== 32'd0) begin
            n_err++;
            $display("FAIL reset_cnt: %0d %0d %0d expected 0 0 0", stallCount, flushCount, freezeCount);
        end
        next_cycle();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_load_use();
        logic [4:0] exp [0:6];
        exp[0] = 5'b11010; exp[1] = 5'b00000; exp[2] = 5'b11010; exp[3] = 5'b00000;
        exp[4] = 5'b00000; exp[5] = 5'b00000; exp[6] = 5'b00000;
        for (int i = 0; i < 7; i++) begin
            idle();
            case (i)
                0: load_use_rs1();
                1: ;
                2: begin lwEX = 1'b1; EscRegEX = 1'b0; rdEX = 5'd9; rs2ID = 5'd9; usesRs2ID = 1'b1; rs1ID = 5'd3; usesRs1ID = 1'b1; end
                3: begin load_use_rs1(); rdEX = 5'd0; rs1ID = 5'd0; end
                4: begin load_use_rs1(); EscRegEX = 1'b1; end
                5: begin load_use_rs1(); usesRs1ID = 1'b0; end
                default: begin load_use_rs1(); lwEX = 1'b0; end
            endcase
            @(negedge clk);
            n_vec++;
            if (ctl !== exp[i]) begin n_err++; $display("FAIL load_use_%0d: ctl=%b expected %b", i, ctl, exp[i]); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_branch();
        idle();
        load_use_rs1();
        branchTakenEX = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== 5'b00110) begin n_err++; $display("FAIL branch_lu: ctl=%b expected %b", ctl, 5'b00110); end
        next_cycle();
        idle();
        branchTakenEX = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== 5'b00110) begin n_err++; $display("FAIL branch_only: ctl=%b expected %b", ctl, 5'b00110); end
        next_cycle();
        idle();
    endtask

    task automatic test_freeze();
        idle();
        memReqMEM = 1'b1; memReadyMEM = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== 5'b00000) begin n_err++; $display("FAIL ready_first: ctl=%b expected %b", ctl, 5'b00000); end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (dut.r_state !== 1'b0) begin n_err++; $display("FAIL ready_first_state: state=%b expected %b", dut.r_state, 1'b0); end
        idle();
        load_use_rs1();
        memReqMEM = 1'b1; memReadyMEM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) branchTakenEX = 1'b1;
            @(negedge clk);
            n_vec++;
            if (ctl !== 5'b11001) begin n_err++; $display("FAIL freeze_%0d: ctl=%b expected %b", i, ctl, 5'b11001); end
            next_cycle();
        end
        branchTakenEX = 1'b0;
        memReadyMEM = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== 5'b11010 || dut.r_state !== 1'b1) begin
            n_err++;
            $display("FAIL freeze_end: ctl=%b state=%b expected %b 1", ctl, dut.r_state, 5'b11010);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (ctl !== 5'b00000 || dut.r_state !== 1'b0 || memTimeout !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_run: ctl=%b state=%b timeout=%b expected 00000 0 0", ctl, dut.r_state, memTimeout);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        idle();
        memReqMEM = 1'b1; memReadyMEM = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (memTimeout !== 1'b0) begin n_err++; $display("FAIL timeout_early_%0d: timeout=%b expected 0", i, memTimeout); end
            next_cycle();
        end
        @(negedge clk);
        n_vec++;
        if (memTimeout !== 1'b1 || ctl !== 5'b11001) begin
            n_err++;
            $display("FAIL timeout_set: timeout=%b ctl=%b expected 1 11001", memTimeout, ctl);
        end
        memReadyMEM = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (memTimeout !== 1'b1 || ctl !== 5'b00000) begin
            n_err++;
            $display("FAIL timeout_sticky: timeout=%b ctl=%b expected 1 00000", memTimeout, ctl);
        end
        do_reset();
        @(negedge clk);
        n_vec++;
        if (memTimeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: timeout=%b expected 0", memTimeout); end
    endtask

    task automatic test_reset_midwait();
        idle();
        memReqMEM = 1'b1; memReadyMEM = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        n_vec++;
        if (dut.r_state !== 1'b1 || dut.r_wait_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL midwait_pre: state=%b waitCnt=%0d expected 1 3", dut.r_state, dut.r_wait_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 5'b00000) begin n_err++; $display("FAIL midwait_rst_ctl: ctl=%b expected %b", ctl, 5'b00000); end
        next_cycle();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_vec++;
        if (dut.r_state !== 1'b0 || dut.r_wait_cnt !== 16'd0 || ctl !== 5'b00000 || memTimeout !== 1'b0) begin
            n_err++;
            $display("FAIL midwait_post: state=%b waitCnt=%0d ctl=%b timeout=%b expected 0 0 00000 0",
                     dut.r_state, dut.r_wait_cnt, ctl, memTimeout);
        end
        // A fresh wait of 7 cycles must not trip the watchdog if the count really restarted.
        memReqMEM = 1'b1;
        repeat (7) next_cycle();
        memReadyMEM = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (memTimeout !== 1'b0) begin n_err++; $display("FAIL midwait_restart: timeout=%b expected 0", memTimeout); end
        next_cycle();
    endtask

    task automatic test_perf_counters();
        logic [CNT_W-1:0] e_stall, e_flush, e_freeze;
`ifdef HAZARD_PERF_CNT_EN
        e_stall = 32'd3; e_flush = 32'd2; e_freeze = 32'd5;
`else
        e_stall = 32'd0; e_flush = 32'd0; e_freeze = 32'd0;
`endif
        do_reset();
        idle();
        load_use_rs1();
        repeat (3) next_cycle();
        idle();
        branchTakenEX = 1'b1;
        repeat (2) next_cycle();
        idle();
        memReqMEM = 1'b1;
        repeat (5) next_cycle();
        memReadyMEM = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (stallCount !== e_stall || flushCount !== e_flush || freezeCount !== e_freeze) begin
            n_err++;
            $display("FAIL perf_cnt: %0d %0d %0d expected %0d %0d %0d",
                     stallCount, flushCount, freezeCount, e_stall, e_flush, e_freeze);
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        next_cycle();
        test_reset();
        test_load_use();
        test_branch();
        test_freeze();
        test_timeout();
        test_reset_midwait();
        test_perf_counters();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
